// File: rtl/display_arbiter.sv
// Round-robin owner of the shared 8-digit/16-LED display path between four clients.
// Enforces a minimum dwell per owner and shows one blank frame on every hand-over.
module display_arbiter #(
  parameter int CLK_FREQ = 25,
  parameter int DWELL_MS = 500
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [31:0]  frame_en,
  input  logic [127:0] frame_data,
  input  logic [31:0]  frame_dot,
  input  logic [63:0]  frame_led,
  output logic [3:0]   grant,
  output logic [1:0]   owner,
  output logic [7:0]   disp_en,
  output logic [31:0]  disp_data,
  output logic [7:0]   disp_dot,
  output logic [15:0]  disp_led,
  output logic         changed
);

  function automatic int GET_WIDTH(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int               DWELL_CYCLES = CLK_FREQ * DWELL_MS * 1000;
  localparam int               CNT_W        = GET_WIDTH(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, OPEN, SWITCH} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] dwell, dwell_next;
  logic             pend, pend_next;
  logic [3:0]       grant_next;
  logic [1:0]       owner_next;
  logic [7:0]       disp_en_next;
  logic [31:0]      disp_data_next;
  logic [7:0]       disp_dot_next;
  logic [15:0]      disp_led_next;
  logic             changed_next;
  logic [1:0]       winner;
  logic [3:0]       owner_mask;
  logic             owner_req;
  logic             others;
  logic             frame_valid;

  // Nearest requester after 'last' wins; 'last' itself only when nobody else asks.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = last;
    for (int i = 3; i >= 1; i--) begin
      idx = last + 2'(i);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_next = state;
    grant_next = grant;
    owner_next = owner;
    dwell_next = dwell;
    pend_next  = 1'b0;
    winner     = rr_pick(req, owner);
    owner_mask = 4'b0001 << owner;
    owner_req  = |(req & owner_mask);
    others     = |(req & ~owner_mask);

    unique case (state)
      IDLE, SWITCH: begin
        state_next = IDLE;
        grant_next = '0;
        if (|req) begin
          state_next = HOLD;
          grant_next = 4'b0001 << winner;
          owner_next = winner;
          dwell_next = '0;
          // A re-grant of the same client right after a hand-over is not a new source.
          pend_next  = (state == IDLE) || (winner != owner);
        end
      end
      HOLD: begin
        if (!owner_req) begin
          state_next = SWITCH;
          grant_next = '0;
        end else if (dwell == DWELL_LAST) begin
          state_next = OPEN;
        end
        if (dwell != DWELL_LAST) dwell_next = dwell + 1'b1;
      end
      OPEN: begin
        if (!owner_req || others) begin
          state_next = SWITCH;
          grant_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase

    // The frame is only shown while the grant is held across the edge; a hand-over blanks it.
    frame_valid    = (|grant) && (state_next != SWITCH);
    disp_en_next   = frame_valid ? frame_en[{owner, 3'd0} +: 8]    : '0;
    disp_data_next = frame_valid ? frame_data[{owner, 5'd0} +: 32] : '0;
    disp_dot_next  = frame_valid ? frame_dot[{owner, 3'd0} +: 8]   : '0;
    disp_led_next  = frame_valid ? frame_led[{owner, 4'd0} +: 16]  : '0;
    changed_next   = pend & frame_valid;
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= 2'd3;
      dwell     <= '0;
      pend      <= 1'b0;
      disp_en   <= '0;
      disp_data <= '0;
      disp_dot  <= '0;
      disp_led  <= '0;
      changed   <= 1'b0;
    end else begin
      state     <= state_next;
      grant     <= grant_next;
      owner     <= owner_next;
      dwell     <= dwell_next;
      pend      <= pend_next;
      disp_en   <= disp_en_next;
      disp_data <= disp_data_next;
      disp_dot  <= disp_dot_next;
      disp_led  <= disp_led_next;
      changed   <= changed_next;
    end
  end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single 8-digit 7-segment + 16-LED display path between 4 requesting clients, e.g. CPU debug view, switch echo, exception/status view and test pattern.
- Round-robin arbiter with a minimum dwell time so the panel never flickers between sources.
- On any ownership change, forces one blank frame.
- Drives the en/data/dot/led inputs of the display block and pulses a frame-change strobe.

Parameters:
- CLK_FREQ, 25, main clock frequency in MHz.
- DWELL_MS, 500, minimum ownership time in ms before another requester may take over.
- DWELL_CYCLES (localparam) = CLK_FREQ*DWELL_MS*1000; dwell counter width derived from it via GET_WIDTH.

Ports:
- clk  in  1  main clock
- rst  in  1  synchronous reset, active-high
- req  in  4  per-client request, level; bit i = client i
- frame_en  in  32  client i tube enables at [8i+7:8i]
- frame_data  in  128  client i digits at [32i+31:32i]
- frame_dot  in  32  client i dots at [8i+7:8i]
- frame_led  in  64  client i LEDs at [16i+15:16i]
- grant  out  4  one-hot owner, or 0
- owner  out  2  index of the current or most recent owner
- disp_en  out  8  to display en
- disp_data  out  32  to display data
- disp_dot  out  8  to display dot
- disp_led  out  16  to display led
- changed  out  1  one-cycle pulse when the first frame of a new owner is presented

Behaviour:
- All outputs registered. Reset values:
  - grant=0, owner=3 (last owner, so client 0 wins first)
  - disp_*=0, changed=0, dwell counter=0, state=IDLE
- Reset mid-operation aborts everything at the next edge and returns to these values.
- States: IDLE, HOLD, OPEN, SWITCH.
- IDLE:
  - grant=0, disp_* blank.
  - If req!=0 at an edge: grant the round-robin winner, load owner, clear dwell counter, go HOLD.
- HOLD:
  - Dwell counter increments each cycle.
  - Other requests are ignored.
  - Counter reaching DWELL_CYCLES-1 -> OPEN.
  - Owner dropping req -> SWITCH, regardless of dwell.
- OPEN:
  - Owner drops req -> SWITCH.
  - Owner holds req and any other req bit set -> SWITCH (preemption).
  - Otherwise stay; counter saturates.
- SWITCH (exactly one cycle):
  - grant=0, disp_* forced blank.
  - At the next edge, if req!=0: grant the round-robin winner, go HOLD; else go IDLE.
- Round-robin:
  - Search starts at owner+1 mod 4 and wraps.
  - The previous owner is eligible only if it is the sole requester.
  - Simultaneous requests resolve purely by this order.
- Frame path:
  - While grant[k]=1, at every edge disp_* <= frame_*[slice k]. Live tracking with one-cycle latency.
  - The first frame appears one edge after grant rises.
  - Disabled tubes are passed as given; the display block blanks them.
- changed:
  - High for exactly the cycle in which disp_* first holds a new grant's frame, i.e. 2 edges after req is sampled from IDLE.
  - Not asserted when the same client is re-granted after SWITCH.
- Widths: all slices are fixed, with no arithmetic on data. The dwell counter must not wrap.

Test Plan:
1. Reset, then req=0001, frame_data[31:0]=32'h12345678 -> edge1: grant=0001, owner=0; edge2: disp_data=12345678, changed=1 for 1 cycle.
2. req=0011 from reset -> client 0 granted. Client 1 ignored until DWELL_CYCLES (CLK_FREQ=1, DWELL_MS=1 -> 1000 cycles). Then one SWITCH cycle (grant=0, disp_* = 0), then grant=0010.
3. Client 0 owns, drops req at cycle 10 of HOLD with req=0100 -> SWITCH for 1 cycle, then grant=0100, changed pulses, disp_led = frame_led[47:32].
4. Owner=3, req=1011 all held, full rotation -> grant sequence 0001, 0010, 1000, 0001. Each grant lasts ≥1000 cycles with exactly one blank cycle between grants.
5. Sole client 2 held for 5000 cycles -> grant stays 0100, no SWITCH, changed=0 after the first pulse. Counter saturates without a spurious preemption.
6. Assert rst in HOLD while disp_data=DEADBEEF -> next edge: grant=0, disp_*=0, owner=3. Release rst with req=0010 -> client 1 granted one edge later.
